// File: rtl/seg7_scan_if.sv
// seg7_scan_if: control and display signals between a host and seg7_scan_ctrl
interface seg7_scan_if #(parameter int N_DIGITS = 4);
  logic en;
  logic load;
  logic lz_en;
  logic [4*N_DIGITS-1:0] din;
  logic [3:0] bcd;
  logic [N_DIGITS-1:0] digit_n;
  logic upd_pend;
  modport master(output en, load, lz_en, din, input bcd, digit_n, upd_pend);
  modport slave(input en, load, lz_en, din, output bcd, digit_n, upd_pend);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: blanked time-multiplexed 7-seg scanner with frame-synchronous double buffering
module seg7_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int DIV_CYCLES = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  seg7_scan_if.slave bus
);
  localparam int CW = $clog2(DIV_CYCLES);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int W = 4 * N_DIGITS;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [W-1:0] shadow, active, active_nx;
  logic frame, pend_nx, zeros, sup;
  logic [3:0] nib;
  logic [N_DIGITS-1:0] dn_nx;
  // Outputs are computed from next-cycle state so the registered values line up with it
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    idx_nx = idx;
    if (!bus.en) begin
      state_nx = IDLE;
      cnt_nx = '0;
      idx_nx = '0;
    end else if (state == IDLE) begin
      state_nx = BLANK;
    end else if (state == BLANK) begin
      cnt_nx = cnt + 1'b1;
      state_nx = cnt == CW'(BLANK_CYCLES - 1) ? SHOW : BLANK;
    end else if (cnt == CW'(DIV_CYCLES - 1)) begin
      state_nx = BLANK;
      cnt_nx = '0;
      idx_nx = idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1;
    end else begin
      cnt_nx = cnt + 1'b1;
    end
    frame = state_nx == BLANK && state != BLANK && idx_nx == '0;
    active_nx = frame ? (bus.load ? bus.din : bus.upd_pend ? shadow : active) : active;
    pend_nx = frame ? 1'b0 : bus.load | bus.upd_pend;
    nib = active_nx[4*int'(idx_nx) +: 4];
    zeros = 1'b1;
    for (int i = 0; i < N_DIGITS; i++)
      if (i >= int'(idx_nx) && active_nx[4*i +: 4] != 4'd0) zeros = 1'b0;
    sup = nib > 4'd9 || (bus.lz_en && idx_nx != '0 && zeros);
    dn_nx = '1;
    if (state_nx == SHOW && !sup) dn_nx[idx_nx] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shadow <= '0;
      active <= '0;
      bus.bcd <= '0;
      bus.digit_n <= '1;
      bus.upd_pend <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      idx <= idx_nx;
      active <= active_nx;
      shadow <= bus.load ? bus.din : shadow;
      bus.bcd <= state_nx == IDLE ? 4'd0 : nib;
      bus.digit_n <= dn_nx;
      bus.upd_pend <= pend_nx;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed stimulus with a scoreboard of expected lit-digit slots
module tb_seg7_scan_ctrl;
  typedef struct {
    logic [3:0] dn;
    logic [3:0] bcd;
    int len;
    int gap;
  } exp_t;
  logic clk = 0;
  logic rst;
  int errors = 0, checks = 0, t = 0;
  exp_t q[$];
  seg7_scan_if #(.N_DIGITS(4)) bus();
  seg7_scan_ctrl #(.N_DIGITS(4), .DIV_CYCLES(8), .BLANK_CYCLES(2)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task tick;
    @(posedge clk);
    #1;
    t++;
  endtask
  task run_to(input int n);
    while (t < n) tick;
  endtask
  task push(input logic [3:0] dn, input logic [3:0] b, input int len, input int gap);
    q.push_back('{dn, b, len, gap});
  endtask
  task chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  // Monitor: one scoreboard entry per lit period (gap < 0 means gap not checked)
  logic prev_lit = 0, lit, glitch = 0;
  logic [3:0] cdn, cb;
  int len = 0, gap = 0, dark = 0;
  exp_t e;
  always @(negedge clk) begin
    lit = (bus.digit_n != 4'hF) === 1'b1;
    if (lit && !prev_lit) begin
      cdn = bus.digit_n;
      cb = bus.bcd;
      len = 1;
      gap = dark;
      glitch = 0;
    end else if (lit) begin
      len++;
      if (bus.digit_n !== cdn || bus.bcd !== cb) glitch = 1;
    end else if (prev_lit) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got dn=%b bcd=%h len=%0d", cdn, cb, len);
      end else begin
        e = q.pop_front();
        if (glitch || cdn !== e.dn || cb !== e.bcd || len != e.len || (e.gap >= 0 && gap != e.gap)) begin
          errors++;
          $display("FAIL sb_slot got dn=%b bcd=%h len=%0d gap=%0d glitch=%0d exp dn=%b bcd=%h len=%0d gap=%0d",
                   cdn, cb, len, gap, glitch, e.dn, e.bcd, e.len, e.gap);
        end
      end
      dark = 1;
    end else begin
      dark++;
    end
    prev_lit = lit;
  end
  initial begin
    rst = 1;
    bus.en = 0;
    bus.load = 0;
    bus.din = 0;
    bus.lz_en = 0;
    repeat (3) tick;
    chk("rst_digit_n", int'(bus.digit_n), 15);
    chk("rst_bcd", int'(bus.bcd), 0);
    chk("rst_upd_pend", int'(bus.upd_pend), 0);
    rst = 0;
    tick;
    bus.din = 16'h1234;
    bus.load = 1;
    tick;
    bus.load = 0;
    chk("idle_load_pend", int'(bus.upd_pend), 1);
    tick;
    chk("idle_load_held", int'(bus.upd_pend), 1);
    push(4'b1110, 4, 6, -1); push(4'b1101, 3, 6, 2); push(4'b1011, 2, 6, 2); push(4'b0111, 1, 6, 2);
    bus.en = 1;
    t = 0;
    tick;
    tick;
    chk("first_blank", int'(bus.digit_n), 15);
    chk("first_commit", int'(bus.upd_pend), 0);
    tick;
    chk("first_light", int'(bus.digit_n), 14);
    chk("first_bcd", int'(bus.bcd), 4);
    run_to(20);
    bus.din = 16'h5678;
    bus.load = 1;
    tick;
    bus.load = 0;
    chk("mid_frame_pend", int'(bus.upd_pend), 1);
    push(4'b1110, 8, 6, 2); push(4'b1101, 7, 6, 2); push(4'b1011, 6, 6, 2); push(4'b0111, 5, 6, 2);
    run_to(32);
    chk("pend_before_frame", int'(bus.upd_pend), 1);
    tick;
    chk("pend_after_frame", int'(bus.upd_pend), 0);
    run_to(64);
    bus.din = 16'h3A21;
    bus.load = 1;
    tick;
    bus.load = 0;
    chk("boundary_load_pend", int'(bus.upd_pend), 0);
    push(4'b1110, 1, 6, 2); push(4'b1101, 2, 6, 2); push(4'b0111, 3, 6, 10);
    tick;
    bus.din = 16'h0090;
    bus.lz_en = 1;
    bus.load = 1;
    tick;
    bus.load = 0;
    chk("lz_load_pend", int'(bus.upd_pend), 1);
    push(4'b1110, 0, 6, 2); push(4'b1101, 9, 6, 2);
    run_to(128);
    bus.lz_en = 0;
    push(4'b1110, 0, 6, 18); push(4'b1101, 9, 6, 2); push(4'b1011, 0, 6, 2); push(4'b0111, 0, 6, 2);
    push(4'b1110, 0, 6, 2); push(4'b1101, 9, 3, 2);
    run_to(173);
    bus.en = 0;
    tick;
    chk("en_off_dark", int'(bus.digit_n), 15);
    run_to(176);
    push(4'b1110, 0, 6, 5); push(4'b1101, 9, 2, 2);
    bus.en = 1;
    t = 0;
    tick;
    tick;
    chk("restart_blank", int'(bus.digit_n), 15);
    tick;
    chk("restart_light", int'(bus.digit_n), 14);
    run_to(12);
    bus.din = 16'h4321;
    bus.load = 1;
    tick;
    bus.load = 0;
    chk("pre_rst_pend", int'(bus.upd_pend), 1);
    rst = 1;
    #1;
    chk("async_rst_digit_n", int'(bus.digit_n), 15);
    chk("async_rst_bcd", int'(bus.bcd), 0);
    chk("async_rst_pend", int'(bus.upd_pend), 0);
    tick;
    rst = 0;
    t = 0;
    push(4'b1110, 0, 6, -1); push(4'b1101, 0, 6, 2); push(4'b1011, 0, 6, 2); push(4'b0111, 0, 6, 2);
    tick;
    tick;
    chk("post_rst_blank", int'(bus.digit_n), 15);
    tick;
    chk("post_rst_light", int'(bus.digit_n), 14);
    chk("post_rst_bcd", int'(bus.bcd), 0);
    run_to(34);
    bus.en = 0;
    tick;
    tick;
    chk("sb_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
